// File: rtl/piano_pkg.sv
// Shared constants, segment table and voice state type for the note voice manager.
package piano_pkg;

  localparam logic [7:0] NOTE_MIN = 8'd2;
  localparam logic [7:0] NOTE_MAX = 8'd11;

  localparam int OCT_MIN_DEF = -3;
  localparam int OCT_MAX_DEF = 3;

  // Active-low abcdefg patterns, element k shows digit k.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {
    VOICE_IDLE = 1'b0,
    VOICE_PLAY = 1'b1
  } voice_state_e;

  // Displayed digit is (code-1) mod 10, so code 11 wraps to "0".
  function automatic logic [6:0] seg_of(input logic [7:0] code);
    logic [7:0] digit;
    digit = (code - 8'd1) % 8'd10;
    return SEG_TABLE[digit[3:0]];
  endfunction

endpackage

// File: rtl/voice_timer.sv
// One voice: IDLE/PLAY state, note register and play timer; load (re)starts the note.
module voice_timer #(
  parameter int unsigned DURATION = 25_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [7:0]       code,
  output logic             active,
  output logic [7:0]       note,
  output logic [CNT_W-1:0] timer
);
  import piano_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DURATION - 1);

  voice_state_e     state;
  voice_state_e     state_next;
  logic [CNT_W-1:0] timer_next;
  logic [7:0]       note_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= VOICE_IDLE;
      timer  <= '0;
      note   <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      timer  <= timer_next;
      note   <= note_next;
      active <= (state_next == VOICE_PLAY);
    end
  end

  // A load beats expiry on the same cycle, so a retrigger never drops the voice.
  always_comb begin
    state_next = state;
    timer_next = timer;
    note_next  = note;
    if (load) begin
      state_next = VOICE_PLAY;
      timer_next = '0;
      note_next  = code;
    end else if (state == VOICE_PLAY) begin
      if (timer == LAST) begin
        state_next = VOICE_IDLE;
        timer_next = '0;
      end else begin
        timer_next = timer + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_voice_manager.sv
// Polyphonic note allocator with retrigger/idle/steal priority, octave shift and digit display.
module note_voice_manager
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned DURATION   = 25_000_000,
  parameter int unsigned CNT_W      = 27,
  parameter int          OCT_MIN    = OCT_MIN_DEF,
  parameter int          OCT_MAX    = OCT_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      note_valid,
  input  logic [7:0]                note_code,
  input  logic                      oct_up,
  input  logic                      oct_down,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [NUM_VOICES*8-1:0]   voice_note,
  output logic signed [3:0]         octave_shift,
  output logic [3:0]                an,
  output logic [6:0]                seg
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [3:0] OCT_HI = 4'(OCT_MAX);
  localparam logic signed [3:0] OCT_LO = 4'(OCT_MIN);

  logic [CNT_W-1:0]      timer [NUM_VOICES];
  logic [NUM_VOICES-1:0] load;
  logic                  accept;
  logic                  hit;
  logic                  idle_found;
  logic [IDX_W-1:0]      hit_idx;
  logic [IDX_W-1:0]      idle_idx;
  logic [IDX_W-1:0]      steal_idx;
  logic [IDX_W-1:0]      sel;
  logic [CNT_W-1:0]      steal_max;
  logic                  up_q;
  logic                  down_q;
  logic                  up_edge;
  logic                  down_edge;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_timer #(
      .DURATION(DURATION),
      .CNT_W   (CNT_W)
    ) u_voice (
      .clk   (clk),
      .reset (reset),
      .load  (load[g]),
      .code  (note_code),
      .active(voice_active[g]),
      .note  (voice_note[8*g +: 8]),
      .timer (timer[g])
    );
  end

  // Retrigger a matching voice, else the lowest idle one, else steal the oldest (lowest index on ties).
  always_comb begin
    accept     = note_valid && (note_code >= NOTE_MIN) && (note_code <= NOTE_MAX);
    hit        = 1'b0;
    hit_idx    = '0;
    idle_found = 1'b0;
    idle_idx   = '0;
    steal_idx  = '0;
    steal_max  = '0;
    load       = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && voice_active[i] && (voice_note[8*i +: 8] == note_code)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!idle_found && !voice_active[i]) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(i);
      end
      if (timer[i] > steal_max) begin
        steal_max = timer[i];
        steal_idx = IDX_W'(i);
      end
    end
    sel = hit ? hit_idx : (idle_found ? idle_idx : steal_idx);
    for (int i = 0; i < NUM_VOICES; i++) begin
      load[i] = accept && (sel == IDX_W'(i));
    end
  end

  assign up_edge   = oct_up & ~up_q;
  assign down_edge = oct_down & ~down_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      octave_shift <= '0;
      an           <= 4'b1110;
      seg          <= 7'b1111111;
    end else begin
      up_q   <= oct_up;
      down_q <= oct_down;
      an     <= 4'b1110;
      if (accept) seg <= seg_of(note_code);
      if (up_edge && !down_edge && (octave_shift < OCT_HI)) begin
        octave_shift <= octave_shift + 4'sd1;
      end else if (down_edge && !up_edge && (octave_shift > OCT_LO)) begin
        octave_shift <= octave_shift - 4'sd1;
      end
    end
  end

endmodule

// File: tb/tb_note_voice_manager.sv
// Self-checking bench: remaining-time voice model compared every cycle, plus directed literal checks.
module tb_note_voice_manager;

  localparam int NV  = 4;
  localparam int DUR = 10;
  localparam int CW  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              note_valid;
  logic [7:0]        note_code;
  logic              oct_up;
  logic              oct_down;
  logic [NV-1:0]     voice_active;
  logic [NV*8-1:0]   voice_note;
  logic signed [3:0] octave_shift;
  logic [3:0]        an;
  logic [6:0]        seg;

  always #5 clk = ~clk;

  note_voice_manager #(
    .NUM_VOICES(NV),
    .DURATION  (DUR),
    .CNT_W     (CW),
    .OCT_MIN   (-3),
    .OCT_MAX   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_valid  (note_valid),
    .note_code   (note_code),
    .oct_up      (oct_up),
    .oct_down    (oct_down),
    .voice_active(voice_active),
    .voice_note  (voice_note),
    .octave_shift(octave_shift),
    .an          (an),
    .seg         (seg)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: cycles left per voice (0 = silent), note per voice, octave, display, previous button levels.
  int         m_rem [NV];
  logic [7:0] m_note [NV];
  int         m_oct;
  logic [6:0] m_seg = 7'b1111111;
  bit         up_prev;
  bit         down_prev;

  logic [6:0] seg_ref [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic [NV-1:0]   exp_active;
  logic [NV*8-1:0] exp_note;
  logic [3:0]      exp_oct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sel;
    int code;
    bit up_e;
    bit down_e;
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        m_rem[i]  = 0;
        m_note[i] = 8'd0;
      end
      m_oct     = 0;
      m_seg     = 7'b1111111;
      up_prev   = 1'b0;
      down_prev = 1'b0;
      return;
    end
    sel  = -1;
    code = int'(note_code);
    if (note_valid && code >= 2 && code <= 11) begin
      for (int i = 0; i < NV; i++)
        if (sel < 0 && m_rem[i] > 0 && m_note[i] == note_code) sel = i;
      for (int i = 0; i < NV; i++)
        if (sel < 0 && m_rem[i] == 0) sel = i;
      if (sel < 0) begin
        sel = 0;
        for (int i = 1; i < NV; i++)
          if (m_rem[i] < m_rem[sel]) sel = i;
      end
      m_seg = seg_ref[(code - 1) % 10];
    end
    for (int i = 0; i < NV; i++) begin
      if (i == sel) begin
        m_rem[i]  = DUR;
        m_note[i] = note_code;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
      end
    end
    up_e   = oct_up && !up_prev;
    down_e = oct_down && !down_prev;
    if (up_e && !down_e) m_oct = (m_oct + 1 > 3) ? 3 : m_oct + 1;
    else if (down_e && !up_e) m_oct = (m_oct - 1 < -3) ? -3 : m_oct - 1;
    up_prev   = oct_up;
    down_prev = oct_down;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] code);
    note_valid = 1'b1;
    note_code  = code;
    cyc();
    note_valid = 1'b0;
    note_code  = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NV; i++) begin
        exp_active[i]       = (m_rem[i] > 0);
        exp_note[8*i +: 8]  = m_note[i];
      end
      exp_oct = 4'(m_oct);
      chk("model_active", {28'd0, voice_active}, {28'd0, exp_active});
      chk("model_note", voice_note, exp_note);
      chk("model_octave", {28'd0, octave_shift}, {28'd0, exp_oct});
      chk("model_seg", {25'd0, seg}, {25'd0, m_seg});
      chk("model_an", {28'd0, an}, 32'hE);
    end
  end

  initial begin
    reset      = 1'b1;
    note_valid = 1'b0;
    note_code  = 8'd0;
    oct_up     = 1'b0;
    oct_down   = 1'b0;
    for (int i = 0; i < NV; i++) begin
      m_rem[i]  = 0;
      m_note[i] = 8'd0;
    end
    m_oct = 0;
    cyc();
    cmp_en = 1'b1;
    chk("reset_active", {28'd0, voice_active}, 32'h0);
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_an", {28'd0, an}, 32'hE);
    reset = 1'b0;
    cyc();

    // Single note, code 5
    do_reset();
    strobe(8'd5);
    for (int k = 0; k < DUR; k++) begin
      chk("single_active", {28'd0, voice_active}, 32'h1);
      if (k == 0) begin
        chk("single_note", {24'd0, voice_note[7:0]}, 32'h5);
        chk("single_seg", {25'd0, seg}, {25'd0, 7'b1001100});
      end
      cyc();
    end
    chk("single_expired", {28'd0, voice_active}, 32'h0);

    // Fill four voices then steal the oldest
    do_reset();
    strobe(8'd2); cyc();
    strobe(8'd3); cyc();
    strobe(8'd4); cyc();
    strobe(8'd5); cyc();
    chk("fill_notes", voice_note, {8'd5, 8'd4, 8'd3, 8'd2});
    strobe(8'd7);
    chk("steal_notes", voice_note, {8'd5, 8'd4, 8'd3, 8'd7});
    chk("steal_active", {28'd0, voice_active}, 32'hF);
    for (int k = 0; k < 4; k++) cyc();
    chk("steal_timer_cleared", {28'd0, voice_active}, 32'hD);

    // Retrigger exactly on the expiry cycle, then out-of-range codes
    do_reset();
    strobe(8'd3);
    for (int k = 0; k < DUR - 1; k++) begin
      chk("retrig_first", {28'd0, voice_active}, 32'h1);
      cyc();
    end
    strobe(8'd3);
    for (int k = 0; k < DUR; k++) begin
      chk("retrig_second", {28'd0, voice_active}, 32'h1);
      cyc();
    end
    chk("retrig_expired", {28'd0, voice_active}, 32'h0);
    strobe(8'd12);
    chk("code12_active", {28'd0, voice_active}, 32'h0);
    chk("code12_seg", {25'd0, seg}, {25'd0, 7'b0010010});
    strobe(8'd0);
    chk("code0_note", voice_note, {24'd0, 8'd3});
    chk("code0_seg", {25'd0, seg}, {25'd0, 7'b0010010});

    // Octave saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      oct_up = 1'b1;
      cyc();
      chk("oct_up_sat", {28'd0, octave_shift}, (k < 3) ? 32'(k + 1) : 32'h3);
      oct_up = 1'b0;
      cyc();
    end
    oct_up   = 1'b1;
    oct_down = 1'b1;
    cyc();
    chk("oct_both", {28'd0, octave_shift}, 32'h3);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      oct_down = 1'b1;
      cyc();
      oct_down = 1'b0;
      cyc();
    end
    chk("oct_down_sat", {28'd0, octave_shift}, 32'hD);

    // Reset while three voices play, with a note strobed in the same cycle
    do_reset();
    oct_up = 1'b1; cyc(); oct_up = 1'b0;
    strobe(8'd2);
    strobe(8'd4);
    strobe(8'd6);
    chk("pre_reset_active", {28'd0, voice_active}, 32'h7);
    reset      = 1'b1;
    note_valid = 1'b1;
    note_code  = 8'd8;
    cyc();
    reset      = 1'b0;
    note_valid = 1'b0;
    note_code  = 8'd0;
    chk("midreset_active", {28'd0, voice_active}, 32'h0);
    chk("midreset_note", voice_note, 32'h0);
    chk("midreset_seg", {25'd0, seg}, 32'h7F);
    chk("midreset_oct", {28'd0, octave_shift}, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      note_valid = ($urandom_range(0, 9) < 4);
      note_code  = 8'($urandom_range(0, 13));
      if ($urandom_range(0, 3) == 0) oct_up = ~oct_up;
      if ($urandom_range(0, 3) == 0) oct_down = ~oct_down;
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset      = 1'b0;
    note_valid = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
